mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width of both requester ports and the memory port.
REQ-002 Parameter ADDR_WIDTH, default 32: byte-address width of both requester ports and the memory port.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: arst  input  1  reset, asynchronous, active-low.
REQ-005 Ports: i_req0, i_we0 (1 each), i_addr0 (ADDR_WIDTH), i_wdata0 (DATA_WIDTH)  inputs  requester 0 (instruction side) request, write enable, address, write data.
REQ-006 Ports: i_req1, i_we1 (1 each), i_addr1 (ADDR_WIDTH), i_wdata1 (DATA_WIDTH)  inputs  requester 1 (data side), same meanings.
REQ-007 Ports: o_ack0, o_ack1 (1 each), o_rdata (DATA_WIDTH)  outputs  one-cycle completion pulse per requester, plus shared registered read data.
REQ-008 Ports: o_mem_read_request, o_mem_write_en (1 each), o_mem_addr (ADDR_WIDTH), o_mem_wdata (DATA_WIDTH)  outputs  drive to the memory.
REQ-009 Ports: i_mem_rdata (DATA_WIDTH), i_mem_successful_access (1)  inputs  memory read data and completion strobe.

Function
REQ-010 The FSM SHALL have states IDLE, BUSY and RESP, plus a 1-bit owner register.
REQ-011 IDLE: if any i_reqN is high, SHALL register the winner in owner and go to BUSY on the next edge; otherwise SHALL stay in IDLE.
REQ-012 BUSY: SHALL drive o_mem_addr, o_mem_wdata, o_mem_write_en (= i_weN) and o_mem_read_request (= ~i_weN) combinationally from the owner's inputs; in IDLE and RESP, o_mem_read_request and o_mem_write_en SHALL be 0, and o_mem_addr and o_mem_wdata SHALL be 0.
REQ-013 BUSY: on an edge where i_mem_successful_access is 1, SHALL capture i_mem_rdata into o_rdata and go to RESP; otherwise SHALL stay in BUSY with no cycle limit.
REQ-014 i_mem_successful_access SHALL be ignored in IDLE and RESP.
REQ-015 RESP: o_ack[owner] SHALL be 1 for exactly this cycle, and o_ack of the other port SHALL be 0; SHALL return to IDLE on the next edge; i_req inputs SHALL be ignored in RESP.
REQ-016 o_rdata SHALL hold its value until the next completion, including after writes (write completions also update it with i_mem_rdata).
REQ-017 Requesters SHALL hold i_reqN, i_weN, i_addrN and i_wdataN stable from assertion until o_ackN; the arbiter does not buffer them.
REQ-018 Minimum latency SHALL be 3 cycles: request seen in IDLE at edge N, BUSY from N, memory done at edge N+1, o_ackN high in cycle N+1..N+2.
REQ-019 A requester holding i_reqN after its ack cycle SHALL be treated as a new request; back-to-back grants are separated by one IDLE cycle.
REQ-020 A deassertion of the owner's i_reqN during BUSY is a protocol violation; the arbiter SHALL still complete the access and pulse ack.

Reset
REQ-021 While arst=0: state=IDLE, owner=0, priority pointer=0, o_rdata=0, all o_ack*=0, all o_mem_* =0.
REQ-022 Reset asserted mid-BUSY SHALL abort immediately (asynchronously) with no ack; after release the FSM SHALL start in IDLE.

Configuration
REQ-023 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: when both requests are present in IDLE, the port not granted last wins; pointer updates on each grant; reset value favours requester 0.
REQ-024 Macro undefined: fixed priority, requester 1 (data) always wins ties; no pointer register exists.
REQ-025 A lone request SHALL be granted identically in both builds.

Verification
REQ-026 Single read: i_req0=1, i_addr0=0x40, memory strobes after 5 BUSY cycles returning 0xDEADBEEF -> o_mem_read_request=1 for 5 cycles, o_ack0 one pulse, o_rdata=0xDEADBEEF.
REQ-027 Single write: i_req1=1, i_we1=1, i_addr1=0x8, i_wdata1=0x12345678 -> o_mem_write_en=1, o_mem_addr=0x8, o_mem_wdata=0x12345678 until strobe, then o_ack1 pulse, o_ack0 stays 0.
REQ-028 Tie, fixed priority: i_req0=i_req1=1 held -> grant order 1,1,1... with requester 0 starved; with MEM_ARBITER_ROUND_ROBIN_EN: order 0,1,0,1 over 4 completions.
REQ-029 Stray strobe: i_mem_successful_access=1 in IDLE with no requests -> no ack, state stays IDLE, o_rdata unchanged.
REQ-030 Reset mid-access: arst=0 during BUSY for requester 0 -> o_mem_read_request drops to 0 immediately, no o_ack0, and the first grant after release takes 3 cycles to ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one outstanding access, IDLE -> BUSY -> RESP.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to requester 1.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_req0,
    input  logic                  i_we0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic                  i_req1,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_ack0,
    output logic                  o_ack1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_mem_read_request,
    output logic                  o_mem_write_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_successful_access
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   winner;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // ptr names the port that wins the next tie; it always points away from the last grant.
    logic ptr;

    always_comb begin
        winner = i_req1;
        if (i_req0 && i_req1) begin
            winner = ptr;
        end
    end
`else
    // A lone request wins outright; on a tie requester 1 wins.
    always_comb begin
        winner = i_req1;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            o_rdata <= '0;
            o_ack0  <= 1'b0;
            o_ack1  <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            ptr     <= 1'b0;
`endif
        end else begin
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req0 || i_req1) begin
                        owner <= winner;
                        state <= BUSY;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        ptr   <= ~winner;
`endif
                    end
                end
                BUSY: begin
                    // Acks are registered here so they are high for exactly the RESP cycle.
                    if (i_mem_successful_access) begin
                        o_rdata <= i_mem_rdata;
                        o_ack0  <= ~owner;
                        o_ack1  <= owner;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        o_mem_read_request = 1'b0;
        o_mem_write_en     = 1'b0;
        o_mem_addr         = '0;
        o_mem_wdata        = '0;
        if (state == BUSY) begin
            if (owner) begin
                o_mem_read_request = ~i_we1;
                o_mem_write_en     = i_we1;
                o_mem_addr         = i_addr1;
                o_mem_wdata        = i_wdata1;
            end else begin
                o_mem_read_request = ~i_we0;
                o_mem_write_en     = i_we0;
                o_mem_addr         = i_addr0;
                o_mem_wdata        = i_wdata0;
            end
        end
    end

endmodule
